// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helpers for the johnson_code_monitor slice.
// Functions take the live word width so one package serves every WIDTH up to JC_MAX_W.
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam int JC_MAX_W = 32;

  function automatic int idx_width(input int width);
    return (width <= 1) ? 1 : $clog2(2 * width);
  endfunction

  // A Johnson word is a single run of ones and a single run of zeros, so it has at most one bit edge.
  function automatic logic jc_legal(input logic [JC_MAX_W-1:0] word, input int width);
    int edges;
    edges = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i < width - 1) && (word[i] != word[i+1])) edges++;
    end
    return (edges <= 1);
  endfunction

  function automatic int jc_decode(input logic [JC_MAX_W-1:0] word, input int width);
    int pc;
    pc = 0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if ((i < width) && word[i]) pc++;
    end
    if (word[width-1]) return pc;
    return (pc == 0) ? 0 : (2 * width - pc);
  endfunction

  function automatic int jc_succ(input int i, input int width);
    return (i == 2 * width - 1) ? 0 : i + 1;
  endfunction

  function automatic int jc_pred(input int i, input int width);
    return (i == 0) ? 2 * width - 1 : i - 1;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson word decoder: legality flag plus phase index (0 for illegal words).
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  logic [JC_MAX_W-1:0] word_ext;

  assign word_ext = JC_MAX_W'(word);
  assign legal    = jc_legal(word_ext, WIDTH);
  assign idx      = legal ? IDX_W'(jc_decode(word_ext, WIDTH)) : '0;

endmodule

// File: rtl/johnson_code_monitor.sv
// Johnson-coded state bus monitor: decode, sequence check, lock FSM and saturating error count.
// Define JOHNSON_REVERSE_EN to accept predecessor transitions and expose the dir output.
module johnson_code_monitor
  import johnson_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 2,
  parameter  int ERR_W    = 8,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] jc_in,
  input  logic             clear,
  output logic             out_valid,
  output logic [IDX_W-1:0] idx,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
`ifdef JOHNSON_REVERSE_EN
  ,
  output logic             dir
`endif
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ref_reg, ref_next;
  logic [RUN_W-1:0] run_reg, run_next, run_inc;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [ERR_W-1:0] err_reg, err_next;
  logic             out_valid_reg;
  logic             illegal_reg, illegal_next;
  logic             seq_err_reg, seq_err_next;
  logic             locked_reg;

  logic             dec_legal;
  logic [IDX_W-1:0] dec_idx;
  logic             is_hold, is_fwd, is_rev;

  johnson_decode #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_decode (
    .word (jc_in),
    .legal(dec_legal),
    .idx  (dec_idx)
  );

  assign is_hold = (dec_idx == ref_reg);
  assign is_fwd  = (dec_idx == IDX_W'(jc_succ(int'(ref_reg), WIDTH)));
`ifdef JOHNSON_REVERSE_EN
  assign is_rev  = (dec_idx == IDX_W'(jc_pred(int'(ref_reg), WIDTH)));
`else
  assign is_rev  = 1'b0;
`endif
  assign run_inc = run_reg + RUN_W'(1);

`ifdef JOHNSON_REVERSE_EN
  logic dir_reg, dir_next;
  // Forward wins when successor and predecessor coincide (degenerate WIDTH=1 ring).
  always_comb begin
    dir_next = dir_reg;
    if (in_valid && dec_legal && (state_reg != HUNT) && !is_hold && (is_fwd || is_rev))
      dir_next = is_rev && !is_fwd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_reg <= 1'b0;
    else        dir_reg <= dir_next;
  end
  assign dir = dir_reg;
`endif

  always_comb begin
    state_next   = state_reg;
    ref_next     = ref_reg;
    run_next     = run_reg;
    idx_next     = idx_reg;
    illegal_next = 1'b0;
    seq_err_next = 1'b0;
    if (in_valid) begin
      idx_next = dec_idx;
      if (!dec_legal) begin
        illegal_next = 1'b1;
        state_next   = HUNT;
        run_next     = '0;
      end else begin
        ref_next = dec_idx;
        case (state_reg)
          SYNC: begin
            if (is_fwd || is_rev) begin
              run_next = run_inc;
              if (run_inc >= RUN_W'(LOCK_CNT)) state_next = LOCK;
            end else if (!is_hold) begin
              run_next = '0;
            end
          end
          LOCK: begin
            if (!(is_hold || is_fwd || is_rev)) begin
              seq_err_next = 1'b1;
              state_next   = SYNC;
              run_next     = '0;
            end
          end
          default: begin
            state_next = SYNC;
            run_next   = '0;
          end
        endcase
      end
    end
  end

  // clear overrides an error reported in the same cycle.
  always_comb begin
    err_next = err_reg;
    if (clear)
      err_next = '0;
    else if ((illegal_next || seq_err_next) && (err_reg != ERR_MAX))
      err_next = err_reg + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HUNT;
      ref_reg       <= '0;
      run_reg       <= '0;
      idx_reg       <= '0;
      err_reg       <= '0;
      out_valid_reg <= 1'b0;
      illegal_reg   <= 1'b0;
      seq_err_reg   <= 1'b0;
      locked_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ref_reg       <= ref_next;
      run_reg       <= run_next;
      idx_reg       <= idx_next;
      err_reg       <= err_next;
      out_valid_reg <= in_valid;
      illegal_reg   <= illegal_next;
      seq_err_reg   <= seq_err_next;
      locked_reg    <= (state_next == LOCK);
    end
  end

  assign out_valid = out_valid_reg;
  assign idx       = idx_reg;
  assign illegal   = illegal_reg;
  assign seq_err   = seq_err_reg;
  assign locked    = locked_reg;
  assign err_count = err_reg;

endmodule

// File: tb/tb_johnson_code_monitor.sv
// Directed, table-driven bench for johnson_code_monitor (WIDTH=4, LOCK_CNT=2, ERR_W=8).
// Expectations adapt when JOHNSON_REVERSE_EN is defined.
module tb_johnson_code_monitor;

`ifdef JOHNSON_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] jc_in;
  logic       clear;
  logic       out_valid;
  logic [2:0] idx;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;
  logic       dir_obs;

  int checks = 0;
  int passed = 0;

  johnson_code_monitor #(
    .WIDTH(4),
    .LOCK_CNT(2),
    .ERR_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .jc_in    (jc_in),
    .clear    (clear),
    .out_valid(out_valid),
    .idx      (idx),
    .illegal  (illegal),
    .seq_err  (seq_err),
    .locked   (locked),
    .err_count(err_count)
`ifdef JOHNSON_REVERSE_EN
    ,
    .dir      (dir_obs)
`endif
  );

`ifndef JOHNSON_REVERSE_EN
  assign dir_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] jc;
    logic       clr;
    logic       ov;
    logic [2:0] idx;
    logic       ill;
    logic       seq;
    logic       lk;
    logic [7:0] err;
    logic       dir;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passed++;
      $display("ok   %s: got %0d", name, act);
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] jc, input logic c);
    @(negedge clk);
    in_valid = v;
    jc_in    = jc;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ov, input logic [2:0] ix, input logic il,
                           input logic sq, input logic lk, input logic [7:0] er);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".idx"},       32'(idx),       32'(ix));
    check({tag, ".illegal"},   32'(illegal),   32'(il));
    check({tag, ".seq_err"},   32'(seq_err),   32'(sq));
    check({tag, ".locked"},    32'(locked),    32'(lk));
    check({tag, ".err_count"}, 32'(err_count), 32'(er));
  endtask

  initial begin
    //          v     jc       clr   ov    idx   ill   seq   lk    err   dir
    vecs[0]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b1100, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1110, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'b0101, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[5]  = '{1'b1, 4'b0011, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[7]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0};
    vecs[8]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0};
    vecs[9]  = '{1'b1, 4'b1110, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0};
    vecs[10] = '{1'b1, 4'b1111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0};
    vecs[11] = '{1'b1, 4'b0111, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[12] = '{1'b1, 4'b0011, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[13] = '{1'b1, 4'b0001, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[14] = '{1'b0, 4'b1111, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[15] = '{1'b0, 4'b0101, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[16] = '{1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[17] = '{1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[18] = '{1'b1, 4'b1000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0};
    vecs[19] = '{1'b1, 4'b1100, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0};
    // Step back 1100 -> 1000: reverse build accepts it, forward-only build flags seq_err.
    vecs[20] = '{1'b1, 4'b1000, 1'b0, 1'b1, 3'd1, 1'b0, !REV, REV, REV ? 8'd0 : 8'd1, REV};
    vecs[21] = '{1'b1, 4'b1100, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, REV, REV ? 8'd0 : 8'd1, 1'b0};
    vecs[22] = '{1'b1, 4'b1010, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, REV ? 8'd1 : 8'd2, 1'b0};
    vecs[23] = '{1'b1, 4'b1111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, REV ? 8'd1 : 8'd2, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    jc_in    = 4'b0000;
    clear    = 1'b0;
    @(posedge clk);
    #1;
    check_all("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    check("reset.dir", 32'(dir_obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].v, vecs[i].jc, vecs[i].clr);
      check_all($sformatf("v%0d", i), vecs[i].ov, vecs[i].idx, vecs[i].ill, vecs[i].seq,
                vecs[i].lk, vecs[i].err);
`ifdef JOHNSON_REVERSE_EN
      check($sformatf("v%0d.dir", i), 32'(dir_obs), 32'(vecs[i].dir));
`endif
    end

    // Saturation of the error counter, then clear racing an error.
    drive(1'b0, 4'b0000, 1'b1);
    check("clr_idle.err_count", 32'(err_count), 32'd0);
    for (int i = 0; i < 255; i++) drive(1'b1, 4'b0101, 1'b0);
    check("sat_reach.err_count", 32'(err_count), 32'd255);
    drive(1'b1, 4'b1001, 1'b0);
    check("sat_hold.err_count", 32'(err_count), 32'd255);
    check("sat_hold.illegal", 32'(illegal), 32'd1);
    drive(1'b1, 4'b0110, 1'b1);
    check("clr_prio.err_count", 32'(err_count), 32'd0);
    check("clr_prio.illegal", 32'(illegal), 32'd1);

    // Asynchronous reset while locked, then reacquisition from HUNT.
    drive(1'b1, 4'b0101, 1'b0);
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b1, 4'b1100, 1'b0);
    check("pre_rst.locked", 32'(locked), 32'd1);
    check("pre_rst.err_count", 32'(err_count), 32'd1);
    @(negedge clk);
    in_valid = 1'b1;
    jc_in    = 4'b1110;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b1000, 1'b0);
    check_all("reacq0", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 4'b1100, 1'b0);
    check_all("reacq1", 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 4'b1110, 1'b0);
    check_all("reacq2", 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
